// File: rtl/i2s_pkg.sv
// Shared I2S types for the stereo transmit and receive paths.
package i2s_pkg;

  localparam int unsigned DefaultDataWidth = 24;

  typedef enum logic [1:0] {
    StSync,
    StLeft,
    StRight
  } i2s_tx_state_t;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] left;
    logic [DefaultDataWidth-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// Registers BCLK/WS (level inputs on clk_ref) and flags BCLK falling edges and WS transitions.
module i2s_edge_detect (
  input  logic clk_ref,
  input  logic reset_n,
  input  logic bclk,
  input  logic ws,
  output logic bclk_fall,
  output logic ws_edge
);

  logic bclk_q;
  logic ws_q;

  assign bclk_fall = bclk_q & ~bclk;
  // WS is only compared at BCLK falls, where the clock generator changes it.
  assign ws_edge   = bclk_fall & (ws != ws_q);

  always_ff @(posedge clk_ref) begin
    if (!reset_n) begin
      bclk_q <= 1'b0;
      ws_q   <= 1'b0;
    end else begin
      bclk_q <= bclk;
      if (bclk_fall) begin
        ws_q <= ws;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips-timing I2S transmitter: one held stereo pair per frame, shifted MSB-first on BCLK falls.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
  parameter int unsigned UNDERRUN_CNT_W = 16
) (
  input  logic                      clk_ref,
  input  logic                      reset_n,
  input  logic                      i2s_bclk,
  input  logic                      i2s_ws,
  input  logic [DATA_WIDTH-1:0]     sample_left,
  input  logic [DATA_WIDTH-1:0]     sample_right,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      i2s_sdata,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  logic                      bclk_fall;
  logic                      ws_edge;
  logic                      frame_start;
  logic                      accept;

  i2s_tx_state_t             state_q;
  stereo_sample_t            hold_q;
  logic                      hold_full_q;
  logic                      ready_q;
  logic [DATA_WIDTH-1:0]     shreg_l_q;
  logic [DATA_WIDTH-1:0]     shreg_r_q;
  logic                      sdata_q;
  logic                      underrun_q;
  logic [UNDERRUN_CNT_W-1:0] underrun_count_q;

  i2s_edge_detect u_edge_detect (
    .clk_ref   (clk_ref),
    .reset_n   (reset_n),
    .bclk      (i2s_bclk),
    .ws        (i2s_ws),
    .bclk_fall (bclk_fall),
    .ws_edge   (ws_edge)
  );

  assign frame_start = ws_edge & ~i2s_ws;
  assign accept      = sample_valid & ready_q;

  assign sample_ready   = ready_q;
  assign i2s_sdata      = sdata_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

  always_ff @(posedge clk_ref) begin
    if (!reset_n) begin
      state_q          <= StSync;
      hold_q           <= '0;
      hold_full_q      <= 1'b0;
      ready_q          <= 1'b0;
      shreg_l_q        <= '0;
      shreg_r_q        <= '0;
      sdata_q          <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      underrun_q <= 1'b0;

      // ready can only be high while the holding register is empty, so accept and a
      // loading frame start never coincide.
      if (accept) begin
        hold_q      <= '{left: sample_left, right: sample_right};
        hold_full_q <= 1'b1;
      end else if (frame_start && hold_full_q) begin
        hold_full_q <= 1'b0;
      end
      ready_q <= ~accept & (frame_start | ~hold_full_q);

      if (frame_start) begin
        if (hold_full_q) begin
          shreg_l_q <= hold_q.left;
          shreg_r_q <= hold_q.right;
        end else begin
          shreg_l_q  <= '0;
          shreg_r_q  <= '0;
          underrun_q <= 1'b1;
          if (~&underrun_count_q) begin
            underrun_count_q <= underrun_count_q + {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      // The WS-edge bit is the I2S delay slot; data follows on the next fall.
      if (ws_edge) begin
        sdata_q <= 1'b0;
      end else if (bclk_fall) begin
        unique case (state_q)
          StLeft: begin
            sdata_q   <= shreg_l_q[DATA_WIDTH-1];
            shreg_l_q <= {shreg_l_q[DATA_WIDTH-2:0], 1'b0};
          end
          StRight: begin
            sdata_q   <= shreg_r_q[DATA_WIDTH-1];
            shreg_r_q <= {shreg_r_q[DATA_WIDTH-2:0], 1'b0};
          end
          default: sdata_q <= 1'b0;
        endcase
      end

      if (ws_edge) begin
        unique case (state_q)
          StSync:  if (!i2s_ws) state_q <= StLeft;
          StLeft:  if (i2s_ws)  state_q <= StRight;
          StRight: if (!i2s_ws) state_q <= StLeft;
          default: state_q <= StSync;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: frame table plus continuous-valid and mid-slot reset runs.
module tb_i2s_tx_serializer;

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 2;

  logic          clk_ref = 1'b0;
  logic          reset_n;
  logic          i2s_bclk;
  logic          i2s_ws;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic          i2s_sdata;
  logic          underrun;
  logic [CW-1:0] underrun_count;

  int n_tests = 0;
  int n_fail  = 0;
  int urun_cycles = 0;

  always #5 clk_ref = ~clk_ref;

  i2s_tx_serializer #(
    .DATA_WIDTH     (DW),
    .UNDERRUN_CNT_W (CW)
  ) dut (
    .clk_ref        (clk_ref),
    .reset_n        (reset_n),
    .i2s_bclk       (i2s_bclk),
    .i2s_ws         (i2s_ws),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .i2s_sdata      (i2s_sdata),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always @(negedge clk_ref) begin
    if (underrun === 1'b1) urun_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One BCLK period: 2 clk_ref low then 2 high; WS changes with the falling edge.
  task automatic bit_clk(input logic ws_val, output logic sd, output logic rdy);
    @(negedge clk_ref);
    i2s_bclk = 1'b0;
    i2s_ws   = ws_val;
    @(negedge clk_ref);
    sd  = i2s_sdata;
    rdy = sample_ready;
    @(negedge clk_ref);
    i2s_bclk = 1'b1;
    @(negedge clk_ref);
  endtask

  task automatic slot(input logic ws_val, input int n, output logic [63:0] pat,
                      output logic rdy0, output logic rdy1);
    logic sd;
    logic rdy;
    pat  = '0;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      bit_clk(ws_val, sd, rdy);
      pat = {pat[62:0], sd};
      if (k == 0) rdy0 = rdy;
      if (k == 1) rdy1 = rdy;
    end
  endtask

  // Expected slot bits: delay zero, data MSB-first, zero pad; truncated at n bits.
  function automatic logic [63:0] exp_slot(input logic [DW-1:0] d, input int n);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < n; k++) begin
      p = {p[62:0], (k >= 1 && k <= int'(DW)) ? d[int'(DW) - k] : 1'b0};
    end
    return p;
  endfunction

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input string name);
    logic done;
    done = 1'b0;
    @(negedge clk_ref);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (sample_ready) done = 1'b1;
      @(negedge clk_ref);
    end
    sample_valid = 1'b0;
    check(name, {62'd0, done, sample_ready}, {62'd0, 1'b1, 1'b0});
  endtask

  typedef struct {
    logic          present;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            len;
    logic [CW-1:0] cnt;
  } frame_t;

  frame_t        tbl[8];
  logic [63:0]   pl, pr;
  logic          r0, r1, rx, ry;
  int            u0;
  int            n_acc;
  logic          stop;
  logic          last_vr;
  logic [DW-1:0] cont_word;
  logic [DW-1:0] base;
  logic [DW-1:0] exp_l, exp_r;

  initial begin
    tbl[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 32, 2'd0};
    tbl[1] = '{1'b1, 24'h123456, 24'hFEDCBA, 26, 2'd0};
    tbl[2] = '{1'b1, 24'h800001, 24'h7FFFFE, 20, 2'd0};
    tbl[3] = '{1'b0, 24'h000000, 24'h000000, 32, 2'd1};
    tbl[4] = '{1'b0, 24'h000000, 24'h000000, 32, 2'd2};
    tbl[5] = '{1'b0, 24'h000000, 24'h000000, 32, 2'd3};
    tbl[6] = '{1'b0, 24'h000000, 24'h000000, 32, 2'd3};
    tbl[7] = '{1'b1, 24'hC0FFEE, 24'h0BADF0, 25, 2'd3};

    reset_n      = 1'b0;
    i2s_bclk     = 1'b1;
    i2s_ws       = 1'b1;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    repeat (3) @(negedge clk_ref);
    check("reset_ready", sample_ready, 0);
    check("reset_sdata", i2s_sdata, 0);
    check("reset_underrun", underrun, 0);
    check("reset_count", underrun_count, 0);
    reset_n = 1'b1;
    @(negedge clk_ref);
    check("ready_after_reset", sample_ready, 1);

    slot(1'b1, 4, pl, r0, r1);
    check("sync_idle", pl, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].present) push(tbl[i].l, tbl[i].r, $sformatf("f%0d_push", i));
      u0 = urun_cycles;
      slot(1'b0, tbl[i].len, pl, r0, r1);
      slot(1'b1, tbl[i].len, pr, r0, r1);
      exp_l = tbl[i].present ? tbl[i].l : '0;
      exp_r = tbl[i].present ? tbl[i].r : '0;
      check($sformatf("f%0d_left", i), pl, exp_slot(exp_l, tbl[i].len));
      check($sformatf("f%0d_right", i), pr, exp_slot(exp_r, tbl[i].len));
      check($sformatf("f%0d_underrun_pulses", i), 64'(urun_cycles - u0),
            tbl[i].present ? 64'd0 : 64'd1);
      check($sformatf("f%0d_count", i), underrun_count, tbl[i].cnt);
    end

    // Continuous valid: one pair per frame, ready back one clk after each frame start.
    base      = 24'hFFFF00;
    cont_word = base;
    n_acc     = 0;
    stop      = 1'b0;
    last_vr   = 1'b0;
    u0        = urun_cycles;
    @(posedge clk_ref);
    #1;
    sample_left  = cont_word;
    sample_right = ~cont_word;
    sample_valid = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk_ref);
        for (int k = 0; k < 3; k++) begin
          slot(1'b0, 32, pl, r0, r1);
          slot(1'b1, 32, pr, rx, ry);
          check($sformatf("cont%0d_left", k), pl, exp_slot(base + DW'(k), 32));
          check($sformatf("cont%0d_right", k), pr, exp_slot(~(base + DW'(k)), 32));
          check($sformatf("cont%0d_ready_rise", k), r0, 1);
          check($sformatf("cont%0d_ready_drop", k), r1, 0);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk_ref);
          if (last_vr) begin
            n_acc++;
            cont_word    = cont_word + 1'b1;
            sample_left  = cont_word;
            sample_right = ~cont_word;
          end
          last_vr = sample_valid && sample_ready;
        end
      end
    join
    check("cont_accepts", 64'(n_acc), 64'd4);
    check("cont_no_underrun", 64'(urun_cycles - u0), 64'd0);
    @(posedge clk_ref);
    #1;
    sample_valid = 1'b0;

    // Held pair FFFF03 starts shifting; reset 8 bits into the left slot.
    slot(1'b0, 8, pl, r0, r1);
    check("pre_reset_left", pl, exp_slot(base + 24'd3, 8));
    check("pre_reset_sdata", i2s_sdata, 1);
    reset_n = 1'b0;
    @(negedge clk_ref);
    check("mid_reset_sdata", i2s_sdata, 0);
    check("mid_reset_ready", sample_ready, 0);
    check("mid_reset_count", underrun_count, 0);
    repeat (2) @(negedge clk_ref);
    reset_n = 1'b1;
    @(negedge clk_ref);
    check("post_reset_ready", sample_ready, 1);
    u0 = urun_cycles;
    slot(1'b0, 24, pl, r0, r1);
    check("post_reset_left_rest", pl, 0);
    slot(1'b1, 32, pr, r0, r1);
    check("post_reset_right_sync", pr, 0);
    push(24'hC3C3C3, 24'h3C3C3C, "post_reset_push");
    slot(1'b0, 32, pl, r0, r1);
    slot(1'b1, 32, pr, r0, r1);
    check("resume_left", pl, exp_slot(24'hC3C3C3, 32));
    check("resume_right", pr, exp_slot(24'h3C3C3C, 32));
    check("resume_no_underrun", 64'(urun_cycles - u0), 64'd0);
    check("resume_count", underrun_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
